alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes MUL (Rm*Rs) and MLA (Rm*Rs+Rn) by driving the shared EXE-stage ALU through repeated ADD operations (shift-and-add).
It sits beside the ALU in the execute stage and owns the ALU command and operand inputs while busy; the pipeline stalls on busy.
On completion it delivers the 32-bit product and an updated status nibble with a write-enable.

---
 rtl/alu_mul_sequencer_pkg.sv | 25 ++
 rtl/alu_mul_sequencer.sv | 114 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer:
// ALU command encodings, status-register bit positions and FSM state codes.
package alu_mul_sequencer_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam int SR_V = 0;
    localparam int SR_C = 1;
    localparam int SR_Z = 2;
    localparam int SR_N = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_sequencer.sv
// MUL/MLA controller: borrows the EXE-stage ALU for one ADD per multiplier bit,
// stopping early once the remaining multiplier bits are all zero.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_mla,
    input  logic              s_bit,
    input  logic              flush,
    input  logic [DATA_W-1:0] rm,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rn,
    input  logic [3:0]        sr_in,
    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_val1,
    output logic [DATA_W-1:0] alu_val2,
    output logic              alu_c,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        sr_out,
    output logic              sr_we,
    output state_t            state_dbg
);

    // Handshake: start is sampled only in IDLE (and only without flush); busy covers
    // RUN and DONE; done is a one-cycle pulse with result/sr_out/sr_we valid alongside it.
    state_t             state, state_n;
    logic [DATA_W-1:0]  mcand, mplier, acc;
    logic [CNT_W-1:0]   cnt;
    logic               s_q, c_q, v_q;
    logic [DATA_W-1:0]  result_q;
    logic [3:0]         sr_q, sr_now;
    logic               last_iter;

    assign last_iter = ((mplier >> 1) == '0) || (cnt == CNT_W'(DATA_W - 1));
    assign sr_now    = {acc[DATA_W-1], acc == '0, c_q, v_q};

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start && !flush) state_n = (rs != '0) ? ST_RUN : ST_DONE;
            ST_RUN: begin
                if (flush)          state_n = ST_IDLE;
                else if (last_iter) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign alu_cmd   = (state == ST_RUN) ? EXE_ADD : EXE_MOV;
    assign alu_val1  = (state == ST_RUN) ? acc : '0;
    assign alu_val2  = ((state == ST_RUN) && mplier[0]) ? mcand : '0;
    assign alu_c     = 1'b0;

    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign done      = (state == ST_DONE) && !flush;
    assign sr_we     = done && s_q;
    assign result    = (state == ST_DONE) ? acc : result_q;
    assign sr_out    = (state == ST_DONE) ? sr_now : sr_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            result_q <= '0;
            sr_q     <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        mcand  <= rm;
                        mplier <= rs;
                        acc    <= is_mla ? rn : '0;
                        s_q    <= s_bit;
                        c_q    <= sr_in[SR_C];
                        v_q    <= sr_in[SR_V];
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    // Outputs hold the last delivered values once back in IDLE.
                    if (done) begin
                        result_q <= acc;
                        sr_q     <= sr_now;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU beside the DUT, scoreboard of
// expected products/status, directed cases plus randomized operations.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_mla = 1'b0;
    logic        s_bit = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rm = '0, rs = '0, rn = '0;
    logic [3:0]  sr_in = '0;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_val1, alu_val2, alu_result;
    logic        alu_c;
    logic        busy, done, sr_we;
    logic [31:0] result;
    logic [3:0]  sr_out;
    state_t      state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    logic [36:0] exp_q[$];
    logic [31:0] val2_q[$];

    alu_mul_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_mla(is_mla), .s_bit(s_bit),
        .flush(flush), .rm(rm), .rs(rs), .rn(rn), .sr_in(sr_in),
        .alu_cmd(alu_cmd), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_c(alu_c),
        .alu_result(alu_result), .busy(busy), .done(done), .result(result),
        .sr_out(sr_out), .sr_we(sr_we), .state_dbg(state_dbg)
    );

    // External ALU: only MOV and ADD are ever requested by the sequencer.
    assign alu_result = (alu_cmd == EXE_ADD) ? alu_val1 + alu_val2 + {31'b0, alu_c} : alu_val2;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)  done_cnt++;
        if (sr_we) we_cnt++;
        if (alu_cmd == EXE_ADD) val2_q.push_back(alu_val2);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start across one edge, then scrambles operands to prove they were latched.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic mla, input logic s, input logic [3:0] sr);
        @(negedge clk);
        rm = a; rs = b; rn = c; is_mla = mla; s_bit = s; sr_in = sr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rm = $urandom; rs = $urandom; rn = $urandom; sr_in = 4'($urandom);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic mla, input logic s, input logic [3:0] sr, input int poke);
        logic [31:0] res;
        logic [36:0] exp;
        int k;
        int cyc;
        res = a * b + (mla ? c : 32'd0);
        k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        exp_q.push_back({res, res[31], res == 32'd0, sr[1], sr[0], s});
        start_op(a, b, c, mla, s, sr);
        cyc = 1;
        while (!done && cyc < 40) begin
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq("latency", cyc, k + 1);
        exp = exp_q.pop_front();
        if (done) begin
            check_eq("result", result, exp[36:5]);
            check_eq("sr_out", sr_out, exp[4:1]);
            check_eq("sr_we", sr_we, exp[0]);
        end else begin
            check_eq("done_timeout", 0, 1);
        end
        @(negedge clk);
        check_eq("idle_after", {busy, done}, 2'b00);
    endtask

    initial begin
        int base_d, base_w;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", {done, sr_we}, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_sr_out", sr_out, 0);
        check_eq("rst_alu", {alu_cmd, alu_val1, alu_val2, alu_c}, {EXE_MOV, 65'd0});
        rst_n = 1'b1;

        // Plain MUL, ALU operand sequence observed
        val2_q.delete();
        run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0000, 0);
        check_eq("val2_count", val2_q.size(), 3);
        if (val2_q.size() == 3) begin
            check_eq("val2_0", val2_q[0], 32'd0);
            check_eq("val2_1", val2_q[1], 32'd14);
            check_eq("val2_2", val2_q[2], 32'd28);
        end

        run_op(32'd9, 32'd0, 32'd5, 1'b1, 1'b1, 4'b0011, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'b1100, 0);
        run_op(32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b1, 4'b0011, 0);
        base_w = we_cnt;
        run_op(32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b0, 4'b0011, 0);
        check_eq("no_we_s0", we_cnt, base_w);

        // Flush in the second RUN cycle
        base_d = done_cnt; base_w = we_cnt;
        start_op(32'd3, 32'hFF, 32'd0, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        flush = 1'b1;
        check_eq("busy_pre_flush", busy, 1);
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_state", state_dbg, ST_IDLE);
        check_eq("flush_busy", busy, 0);
        repeat (2) @(negedge clk);
        check_eq("flush_no_done", done_cnt, base_d);
        check_eq("flush_no_we", we_cnt, base_w);
        run_op(32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 4'b0000, 0);

        // Flush landing in the DONE cycle suppresses the pulse
        base_d = done_cnt; base_w = we_cnt;
        start_op(32'd5, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        check_eq("at_done_state", state_dbg, ST_DONE);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_done_pulse", done_cnt, base_d);
        check_eq("flush_done_we", we_cnt, base_w);

        // start pulsed mid-RUN is ignored
        run_op(32'd11, 32'h1F, 32'd100, 1'b1, 1'b1, 4'b0010, 2);

        // Reset mid-RUN
        base_d = done_cnt;
        start_op(32'd3, 32'hFF, 32'd0, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_result", result, 0);
        check_eq("midrst_sr_out", sr_out, 0);
        repeat (2) @(negedge clk);
        check_eq("midrst_no_done", done_cnt, base_d);

        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom >> $urandom_range(0, 31), $urandom,
                   1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        check_eq("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
